// File: rtl/wishbone_arbiter_2m.sv
// Two-master Wishbone arbiter with round-robin tie-break, block-transfer hold
// and slave-ack timeout that reports a bus error to the owning master.
module wishbone_arbiter_2m #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_data_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_data_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_addr_o,
  output logic        s_we_o,
  output logic [31:0] s_data_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_owner_q, last_owner_d;
  logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic               req0, req1, own_cyc, own_stb;
  logic [CNT_W:0]     cnt_inc;
  logic               tmo_hit;

  assign req0    = m0_cyc_i & m0_stb_i;
  assign req1    = m1_cyc_i & m1_stb_i;
  assign own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
  assign own_stb = owner_q ? m1_stb_i : m0_stb_i;
  // One extra bit so the saturating compare never sees a wrapped value.
  assign cnt_inc = {1'b0, tmo_cnt_q} + (CNT_W+1)'(1);
  assign tmo_hit = cnt_inc >= (CNT_W+1)'(TIMEOUT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    tmo_cnt_d    = tmo_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d   = BUSY;
          tmo_cnt_d = '0;
          if (req0 && req1) owner_d = ~last_owner_q;
          else              owner_d = req1;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
        end else if (!own_stb || s_ack_i) begin
          tmo_cnt_d = '0;
        end else if (tmo_hit) begin
          state_d   = ERR;
          tmo_cnt_d = CNT_W'(TIMEOUT);
        end else begin
          tmo_cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      ERR: begin
        if (!own_cyc) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus steering: owner's lines pass straight through only while BUSY.
  always_comb begin
    s_addr_o  = '0;
    s_we_o    = 1'b0;
    s_data_o  = '0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    grant_o   = 2'b00;
    m0_data_o = '0;
    m1_data_o = '0;
    m0_ack_o  = 1'b0;
    m1_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_err_o  = 1'b0;
    unique case (state_q)
      BUSY: begin
        grant_o  = owner_q ? 2'b10 : 2'b01;
        s_addr_o = owner_q ? m1_addr_i : m0_addr_i;
        s_we_o   = owner_q ? m1_we_i   : m0_we_i;
        s_data_o = owner_q ? m1_data_i : m0_data_i;
        s_cyc_o  = own_cyc;
        s_stb_o  = own_stb;
        if (owner_q) begin
          m1_ack_o  = s_ack_i & own_cyc;
          m1_data_o = s_data_i;
        end else begin
          m0_ack_o  = s_ack_i & own_cyc;
          m0_data_o = s_data_i;
        end
      end
      ERR: begin
        grant_o  = owner_q ? 2'b10 : 2'b01;
        m0_err_o = ~owner_q;
        m1_err_o = owner_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wishbone_arbiter_2m.sv
// Self-checking bench for wishbone_arbiter_2m: scoreboard of expected acks plus
// per-scenario inline cycle checks.
module tb_wishbone_arbiter_2m;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i, s_data_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i, s_ack_i;
  logic [31:0] m0_data_o, m1_data_o, s_addr_o, s_data_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_we_o, s_cyc_o, s_stb_o;
  logic [1:0]  grant_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          m;
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  wishbone_arbiter_2m #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_data_i(m0_data_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_data_i(m1_data_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_data_o(s_data_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o)
  );

  // Scoreboard: every ack the DUT produces must match the next expected transfer.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] obs_d;
    if (m0_ack_o || m1_ack_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_ack m0_ack=%b m1_ack=%b required none", m0_ack_o, m1_ack_o);
      end else begin
        e = exp_q.pop_front();
        obs_d = e.we ? s_data_o : (m1_ack_o ? m1_data_o : m0_data_o);
        if ({m0_ack_o, m1_ack_o, s_addr_o, obs_d} !== {~e.m, e.m, e.addr, e.data}) begin
          errors++;
          $display("FAIL sb_xfer acks=%b%b addr=%h data=%h required acks=%b%b addr=%h data=%h",
                   m0_ack_o, m1_ack_o, s_addr_o, obs_d, ~e.m, e.m, e.addr, e.data);
        end
      end
    end
    if ((m0_ack_o && m0_err_o) || (m1_ack_o && m1_err_o)) begin
      checks++;
      errors++;
      $display("FAIL ack_err_excl ack=%b%b err=%b%b required no overlap",
               m0_ack_o, m1_ack_o, m0_err_o, m1_err_o);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input bit m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] addr, input logic [31:0] data);
    if (m) begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_addr_i = addr; m1_data_i = data;
    end else begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_addr_i = addr; m0_data_i = data;
    end
  endtask

  task automatic idle_all();
    drive_m(1'b0, 0, 0, 0, 32'h0, 32'h0);
    drive_m(1'b1, 0, 0, 0, 32'h0, 32'h0);
    s_ack_i = 1'b0; s_data_i = 32'h0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive_m(1'b0, 1, 1, 1, 32'h1234, 32'h5678);
    drive_m(1'b1, 0, 0, 0, 32'h0, 32'h0);
    s_ack_i = 1'b1; s_data_i = 32'hFFFF_FFFF;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({grant_o, s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
         s_addr_o, s_data_o, m0_data_o, m1_data_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs grant=%b s_cyc=%b ack=%b%b err=%b%b s_addr=%h required all zero",
               grant_o, s_cyc_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, s_addr_o);
    end
    drive_m(1'b0, 0, 0, 0, 32'h0, 32'h0);
    s_ack_i = 1'b0; s_data_i = 32'h0;
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_write();
    drive_m(1'b0, 1, 1, 1, 32'h0000_0100, 32'h0000_003F);
    @(negedge clk);
    checks++;
    if ({grant_o, s_cyc_o} !== 3'b000) begin
      errors++;
      $display("FAIL wr_latency_idle grant=%b s_cyc=%b required 00 0", grant_o, s_cyc_o);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({grant_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o, m0_ack_o, m1_ack_o} !==
        {2'b01, 3'b111, 32'h0000_0100, 32'h0000_003F, 2'b00}) begin
      errors++;
      $display("FAIL wr_busy grant=%b cyc/stb/we=%b%b%b addr=%h data=%h ack=%b%b required 01 111 00000100 0000003f 00",
               grant_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o, m0_ack_o, m1_ack_o);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({m0_ack_o, m0_err_o, s_cyc_o} !== 3'b001) begin
      errors++;
      $display("FAIL wr_wait ack=%b err=%b s_cyc=%b required 0 0 1", m0_ack_o, m0_err_o, s_cyc_o);
    end
    tick();
    s_ack_i = 1'b1;
    exp_q.push_back('{m: 1'b0, we: 1'b1, addr: 32'h0000_0100, data: 32'h0000_003F});
    @(negedge clk);
    checks++;
    if ({m0_ack_o, m1_ack_o, grant_o} !== 4'b1001) begin
      errors++;
      $display("FAIL wr_ack ack=%b%b grant=%b required 10 01", m0_ack_o, m1_ack_o, grant_o);
    end
    tick();
    drive_m(1'b0, 0, 0, 0, 32'h0, 32'h0);
    s_ack_i = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({grant_o, s_cyc_o} !== 3'b000) begin
      errors++;
      $display("FAIL wr_release grant=%b s_cyc=%b required 00 0", grant_o, s_cyc_o);
    end
    tick();
  endtask

  task automatic test_round_robin();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    drive_m(1'b0, 1, 1, 0, 32'h0000_0200, 32'h0);
    drive_m(1'b1, 1, 1, 0, 32'h0000_0300, 32'h0);
    tick();
    s_ack_i = 1'b1; s_data_i = 32'h1111_0000;
    exp_q.push_back('{m: 1'b0, we: 1'b0, addr: 32'h0000_0200, data: 32'h1111_0000});
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b01) begin
      errors++;
      $display("FAIL rr_first grant=%b required 01", grant_o);
    end
    tick();
    drive_m(1'b0, 0, 0, 0, 32'h0, 32'h0);
    s_ack_i = 1'b0;
    tick();
    drive_m(1'b0, 1, 1, 0, 32'h0000_0200, 32'h0);
    @(negedge clk);
    checks++;
    if ({grant_o, s_cyc_o} !== 3'b000) begin
      errors++;
      $display("FAIL rr_gap grant=%b s_cyc=%b required 00 0", grant_o, s_cyc_o);
    end
    tick();
    s_ack_i = 1'b1; s_data_i = 32'h2222_0000;
    exp_q.push_back('{m: 1'b1, we: 1'b0, addr: 32'h0000_0300, data: 32'h2222_0000});
    @(negedge clk);
    checks++;
    if ({grant_o, s_addr_o} !== {2'b10, 32'h0000_0300}) begin
      errors++;
      $display("FAIL rr_second grant=%b addr=%h required 10 00000300", grant_o, s_addr_o);
    end
    tick();
    drive_m(1'b1, 0, 0, 0, 32'h0, 32'h0);
    s_ack_i = 1'b0;
    tick();
    drive_m(1'b1, 1, 1, 0, 32'h0000_0300, 32'h0);
    tick();
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b01) begin
      errors++;
      $display("FAIL rr_third grant=%b required 01", grant_o);
    end
    idle_all();
  endtask

  task automatic test_no_preempt();
    drive_m(1'b1, 1, 1, 0, 32'h0000_0400, 32'h0);
    tick();
    drive_m(1'b0, 1, 1, 1, 32'h0000_0500, 32'hDEAD_BEEF);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({grant_o, m0_ack_o, s_addr_o} !== {2'b10, 1'b0, 32'h0000_0400}) begin
        errors++;
        $display("FAIL np_hold[%0d] grant=%b m0_ack=%b addr=%h required 10 0 00000400",
                 i, grant_o, m0_ack_o, s_addr_o);
      end
      tick();
    end
    m1_stb_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({grant_o, s_cyc_o, s_stb_o} !== 4'b1010) begin
      errors++;
      $display("FAIL np_stb_gap grant=%b cyc=%b stb=%b required 10 1 0", grant_o, s_cyc_o, s_stb_o);
    end
    tick();
    m1_stb_i = 1'b1;
    s_ack_i = 1'b1; s_data_i = 32'hA5A5_A5A5;
    exp_q.push_back('{m: 1'b1, we: 1'b0, addr: 32'h0000_0400, data: 32'hA5A5_A5A5});
    @(negedge clk);
    checks++;
    if ({m1_data_o, m0_data_o, m1_ack_o, m0_ack_o} !== {32'hA5A5_A5A5, 32'h0, 2'b10}) begin
      errors++;
      $display("FAIL np_read m1_data=%h m0_data=%h ack=%b%b required a5a5a5a5 00000000 01",
               m1_data_o, m0_data_o, m0_ack_o, m1_ack_o);
    end
    tick();
    drive_m(1'b1, 0, 0, 0, 32'h0, 32'h0);
    s_ack_i = 1'b0; s_data_i = 32'h0;
    tick();
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b00) begin
      errors++;
      $display("FAIL np_gap grant=%b required 00", grant_o);
    end
    tick();
    s_ack_i = 1'b1;
    exp_q.push_back('{m: 1'b0, we: 1'b1, addr: 32'h0000_0500, data: 32'hDEAD_BEEF});
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b01) begin
      errors++;
      $display("FAIL np_after grant=%b required 01", grant_o);
    end
    tick();
    idle_all();
  endtask

  task automatic test_timeout();
    drive_m(1'b0, 1, 1, 1, 32'h0000_0600, 32'h0000_0001);
    tick();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if ({s_cyc_o, m0_err_o, grant_o} !== 4'b1001) begin
        errors++;
        $display("FAIL tmo_stall[%0d] s_cyc=%b err=%b grant=%b required 1 0 01",
                 i, s_cyc_o, m0_err_o, grant_o);
      end
      tick();
    end
    s_ack_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({grant_o, s_cyc_o, s_stb_o, m0_err_o, m1_err_o, m0_ack_o} !== 7'b0100100) begin
        errors++;
        $display("FAIL tmo_err[%0d] grant=%b cyc=%b stb=%b err=%b%b ack=%b required 01 0 0 10 0",
                 i, grant_o, s_cyc_o, s_stb_o, m0_err_o, m1_err_o, m0_ack_o);
      end
      tick();
    end
    drive_m(1'b0, 0, 0, 0, 32'h0, 32'h0);
    s_ack_i = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({grant_o, m0_err_o, m1_err_o} !== 4'b0000) begin
      errors++;
      $display("FAIL tmo_exit grant=%b err=%b%b required 00 00", grant_o, m0_err_o, m1_err_o);
    end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    drive_m(1'b1, 1, 1, 0, 32'h0000_0700, 32'h0);
    tick();
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b10) begin
      errors++;
      $display("FAIL rm_busy grant=%b required 10", grant_o);
    end
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    s_ack_i = 1'b1; s_data_i = 32'h7777_7777;
    drive_m(1'b0, 1, 1, 0, 32'h0000_0800, 32'h0);
    @(negedge clk);
    checks++;
    if ({grant_o, s_cyc_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m1_data_o} !== '0) begin
      errors++;
      $display("FAIL rm_idle grant=%b s_cyc=%b ack=%b%b err=%b%b m1_data=%h required all zero",
               grant_o, s_cyc_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m1_data_o);
    end
    tick();
    s_ack_i = 1'b0; s_data_i = 32'h0;
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b01) begin
      errors++;
      $display("FAIL rm_tie grant=%b required 01", grant_o);
    end
    tick();
    idle_all();
  endtask

  initial begin
    rst_i = 1'b1;
    s_ack_i = 1'b0; s_data_i = 32'h0;
    drive_m(1'b0, 0, 0, 0, 32'h0, 32'h0);
    drive_m(1'b1, 0, 0, 0, 32'h0, 32'h0);
    test_reset();
    test_write();
    test_round_robin();
    test_no_preempt();
    test_timeout();
    test_reset_mid_busy();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover pending=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
